// File: rtl/reg_bus_datapath.sv
// Single-bus register datapath: register file, Y/Z staging, HI/LO and ALU driven by a
// three-step micro-sequencer. Define R0_ZERO_EN to hard-wire R0 to zero.
module reg_bus_datapath #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    rb,
  input  logic [AW-1:0]    rd,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             zero,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SW = $clog2(WIDTH);

`ifdef R0_ZERO_EN
  localparam bit R0_HARD = 1'b1;
`else
  localparam bit R0_HARD = 1'b0;
`endif

  // Handshake: start is sampled only in IDLE; the op is latched at that edge and
  // done pulses for exactly one cycle after write-back (err is valid only with done).
  typedef enum logic [1:0] {IDLE, T_A, T_B, T_WB} state_t;

  state_t               state;
  logic [WIDTH-1:0]     regs [NREGS];
  logic [WIDTH-1:0]     y_q;
  logic [2*WIDTH-1:0]   z_q;
  logic [3:0]           op_q;
  logic [AW-1:0]        ra_q, rb_q, rd_q;
  logic [WIDTH-1:0]     bus;
  logic [2*WIDTH-1:0]   alu;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quot, rem;
  logic [2*WIDTH-1:0]   dbl;
  logic [SW-1:0]        sh;
  logic                 legal, mul_div;

  function automatic logic [WIDTH-1:0] rf_rd(input logic [AW-1:0] a);
    return (R0_HARD && a == '0) ? '0 : regs[a];
  endfunction

  function automatic logic wr_ok(input logic [AW-1:0] a);
    return !(R0_HARD && a == '0);
  endfunction

  assign rd_data = rf_rd(rd_addr);
  assign legal   = (op_q <= 4'd12);
  assign mul_div = (op_q == 4'd9) || (op_q == 4'd10);

  always_comb begin
    bus = '0;
    case (state)
      T_A:     bus = rf_rd(ra_q);
      T_B:     bus = rf_rd(rb_q);
      T_WB:    bus = z_q[WIDTH-1:0];
      default: bus = '0;
    endcase
  end

  always_comb begin
    sh   = bus[SW-1:0];
    dbl  = {y_q, y_q};
    prod = $signed({{WIDTH{y_q[WIDTH-1]}}, y_q}) * $signed({{WIDTH{bus[WIDTH-1]}}, bus});
    quot = '0;
    rem  = '0;
    if (bus != '0) begin
      quot = $signed(y_q) / $signed(bus);
      rem  = $signed(y_q) % $signed(bus);
    end
    alu = '0;
    case (op_q)
      4'd0:  alu = {{WIDTH{1'b0}}, y_q + bus};
      4'd1:  alu = {{WIDTH{1'b0}}, y_q - bus};
      4'd2:  alu = {{WIDTH{1'b0}}, y_q & bus};
      4'd3:  alu = {{WIDTH{1'b0}}, y_q | bus};
      4'd4:  alu = {{WIDTH{1'b0}}, y_q >> sh};
      4'd5:  alu = {{WIDTH{1'b0}}, $signed(y_q) >>> sh};
      4'd6:  alu = {{WIDTH{1'b0}}, y_q << sh};
      4'd7:  alu = {{WIDTH{1'b0}}, WIDTH'(dbl >> sh)};
      4'd8:  alu = {{WIDTH{1'b0}}, WIDTH'((dbl << sh) >> WIDTH)};
      4'd9:  alu = prod;
      // Divide by zero leaves the dividend in HI and saturates the quotient.
      4'd10: alu = (bus == '0) ? {y_q, {WIDTH{1'b1}}} : {rem, quot};
      4'd11: alu = {{WIDTH{1'b0}}, -y_q};
      4'd12: alu = {{WIDTH{1'b0}}, ~y_q};
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      y_q   <= '0;
      z_q   <= '0;
      hi    <= '0;
      lo    <= '0;
      op_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rd_q  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      zero  <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_en && wr_ok(ld_addr)) regs[ld_addr] <= ld_data;
          if (start) begin
            op_q  <= op;
            ra_q  <= ra;
            rb_q  <= rb;
            rd_q  <= rd;
            busy  <= 1'b1;
            state <= T_A;
          end
        end
        T_A: begin
          y_q   <= bus;
          state <= T_B;
        end
        T_B: begin
          z_q   <= alu;
          state <= T_WB;
        end
        T_WB: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          if (!legal) begin
            err <= 1'b1;
          end else begin
            zero <= (z_q[WIDTH-1:0] == '0);
            if (mul_div) begin
              hi <= z_q[2*WIDTH-1:WIDTH];
              lo <= z_q[WIDTH-1:0];
            end else if (wr_ok(rd_q)) begin
              regs[rd_q] <= bus;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_datapath.sv
// Directed bench for reg_bus_datapath: stimulus pushes expected results, a monitor
// pops and compares them whenever done pulses.
module tb_reg_bus_datapath;
  localparam int W  = 32;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          clear = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    op = '0;
  logic [AW-1:0] ra = '0, rb = '0, rd = '0, ld_addr = '0, rd_addr = '0;
  logic          ld_en = 1'b0;
  logic [W-1:0]  ld_data = '0;
  logic          busy, done, err, zero;
  logic [W-1:0]  rd_data, hi, lo;

  typedef struct packed {
    logic         err;
    logic         zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] rdv;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;

  reg_bus_datapath #(.WIDTH(W), .NREGS(16)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .ra(ra), .rb(rb), .rd(rd),
    .busy(busy), .done(done), .err(err), .zero(zero),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .hi(hi), .lo(lo)
  );

  // clock/reset
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected finish before 100us");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic e, input logic z, input logic [W-1:0] h,
                              input logic [W-1:0] l, input logic [W-1:0] r);
    return {e, z, h, l, r};
  endfunction

  // monitor / scoreboard
  always @(posedge clock) begin
    #1;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        mon_e = exp_q.pop_front();
        chk("err", {31'b0, err}, {31'b0, mon_e.err});
        chk("zero", {31'b0, zero}, {31'b0, mon_e.zero});
        chk("hi", hi, mon_e.hi);
        chk("lo", lo, mon_e.lo);
        chk("rd_data", rd_data, mon_e.rdv);
      end
    end
  end

  // driver tasks: all start and end just after a falling edge
  task automatic load(input logic [AW-1:0] a, input logic [W-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clock);
    ld_en = 1'b0;
  endtask

  task automatic issue(input logic [3:0] o, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [AW-1:0] d, input exp_t e);
    start = 1'b1; op = o; ra = a; rb = b; rd = d; rd_addr = d;
    exp_q.push_back(e);
    @(negedge clock);
    start = 1'b0;
    ld_en = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk("done_seen", {31'b0, done}, 32'd1);
  endtask

  task automatic run(input logic [3:0] o, input logic [AW-1:0] a, input logic [AW-1:0] b,
                     input logic [AW-1:0] d, input exp_t e);
    issue(o, a, b, d, e);
    wait_done();
  endtask

  task automatic peek(input logic [AW-1:0] a, input logic [W-1:0] exp, input string name);
    rd_addr = a;
    #1;
    chk(name, rd_data, exp);
  endtask

  localparam logic [W-1:0] H = 32'hFFFF_FFFD;
  localparam logic [W-1:0] L = 32'hFFFF_FFFF;

  initial begin
    int dcount;
    repeat (2) @(negedge clock);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    peek(4'd5, 32'd0, "rst_r5");
    clear = 1'b0;
    @(negedge clock);

    // abort in T_B
    load(4'd1, 32'd5);
    load(4'd2, 32'd7);
    start = 1'b1; op = 4'd0; ra = 4'd1; rb = 4'd2; rd = 4'd3;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    @(negedge clock);
    clear = 1'b0;
    peek(4'd1, 32'd0, "abort_r1");
    peek(4'd2, 32'd0, "abort_r2");
    peek(4'd3, 32'd0, "abort_r3");
    dcount = 0;
    repeat (6) begin
      @(negedge clock);
      if (done === 1'b1) dcount++;
    end
    chk("abort_no_done", dcount, 32'd0);

    // ADD latency, start held during busy with changed operands
    load(4'd1, 32'd5);
    load(4'd2, 32'd7);
    exp_q.push_back(mk(1'b0, 1'b0, 32'd0, 32'd0, 32'd12));
    start = 1'b1; op = 4'd0; ra = 4'd1; rb = 4'd2; rd = 4'd3; rd_addr = 4'd3;
    @(negedge clock);
    chk("lat_busy_k", {31'b0, busy}, 32'd1);
    chk("lat_done_k", {31'b0, done}, 32'd0);
    op = 4'd1; ra = 4'd2; rb = 4'd1; rd = 4'd4;
    @(negedge clock);
    chk("lat_busy_k1", {31'b0, busy}, 32'd1);
    chk("lat_done_k1", {31'b0, done}, 32'd0);
    @(negedge clock);
    chk("lat_busy_k2", {31'b0, busy}, 32'd1);
    chk("lat_done_k2", {31'b0, done}, 32'd0);
    start = 1'b0;
    @(negedge clock);
    chk("lat_busy_k3", {31'b0, busy}, 32'd0);
    chk("lat_done_k3", {31'b0, done}, 32'd1);
    @(negedge clock);
    chk("lat_done_k4", {31'b0, done}, 32'd0);
    peek(4'd4, 32'd0, "lat_r4_untouched");

    // MUL / DIV
    load(4'd4, 32'hFFFF_FFFD);
    load(4'd5, 32'd4);
    load(4'd6, 32'd0);
    load(4'd9, 32'h1234);
    run(4'd9,  4'd4, 4'd5, 4'd9, mk(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 32'h1234));
    run(4'd10, 4'd4, 4'd5, 4'd9, mk(1'b0, 1'b1, 32'hFFFF_FFFD, 32'h0, 32'h1234));
    run(4'd10, 4'd4, 4'd6, 4'd9, mk(1'b0, 1'b0, H, L, 32'h1234));

    // shifts, rotates and remaining ALU ops
    load(4'd1, 32'h8000_0001);
    load(4'd2, 32'd33);
    run(4'd4,  4'd1, 4'd2, 4'd10, mk(1'b0, 1'b0, H, L, 32'h4000_0000));
    run(4'd5,  4'd1, 4'd2, 4'd10, mk(1'b0, 1'b0, H, L, 32'hC000_0000));
    run(4'd6,  4'd1, 4'd2, 4'd10, mk(1'b0, 1'b0, H, L, 32'h0000_0002));
    run(4'd7,  4'd1, 4'd2, 4'd10, mk(1'b0, 1'b0, H, L, 32'hC000_0000));
    run(4'd8,  4'd1, 4'd2, 4'd10, mk(1'b0, 1'b0, H, L, 32'h0000_0003));
    run(4'd1,  4'd2, 4'd1, 4'd11, mk(1'b0, 1'b0, H, L, 32'h8000_0020));
    run(4'd2,  4'd1, 4'd2, 4'd11, mk(1'b0, 1'b0, H, L, 32'h0000_0001));
    run(4'd3,  4'd1, 4'd2, 4'd11, mk(1'b0, 1'b0, H, L, 32'h8000_0021));
    run(4'd11, 4'd1, 4'd2, 4'd11, mk(1'b0, 1'b0, H, L, 32'h7FFF_FFFF));
    run(4'd12, 4'd1, 4'd2, 4'd11, mk(1'b0, 1'b0, H, L, 32'h7FFF_FFFE));

    // load together with start, load during busy, reserved opcode
    load(4'd8, 32'h55);
    ld_en = 1'b1; ld_addr = 4'd7; ld_data = 32'd9;
    issue(4'd1, 4'd7, 4'd7, 4'd8, mk(1'b0, 1'b1, H, L, 32'd0));
    ld_en = 1'b1; ld_addr = 4'd7; ld_data = 32'hDEAD;
    @(negedge clock);
    ld_en = 1'b0;
    wait_done();
    run(4'd14, 4'd1, 4'd2, 4'd8, mk(1'b1, 1'b1, H, L, 32'd0));
    peek(4'd7, 32'd9, "ld_busy_ignored");

    // R0 behaviour
    load(4'd0, 32'hAA);
`ifdef R0_ZERO_EN
    run(4'd0, 4'd0, 4'd0, 4'd1, mk(1'b0, 1'b1, H, L, 32'd0));
    peek(4'd0, 32'd0, "r0_reads_zero");
`else
    run(4'd0, 4'd0, 4'd0, 4'd1, mk(1'b0, 1'b0, H, L, 32'h154));
    peek(4'd0, 32'hAA, "r0_plain");
`endif

    repeat (3) @(negedge clock);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_bus_datapath.md
Name: reg_bus_datapath

Overview:
- Parametrised successor to the single-bus CPU datapath.
- Holds a WIDTH-bit, NREGS-deep general register file, Y/Z staging registers, HI/LO, and an ALU, all on one internal bus.
- A built-in 3-step micro-sequencer (T_A, T_B, T_WB) executes one register-register op per start/done handshake.
- Replaces external one-hot Rin/Rout strobes with encoded register addresses; an external load port and read port exist for initialisation and debug.

Parameters:
- WIDTH, 32, data width of registers, bus, ALU, HI and LO.
- NREGS, 16, number of general registers; power of two, at least 2. AW = clog2(NREGS) is derived and is not a parameter.

Ports:
- clock  in  1  single system clock; rising edge.
- clear  in  1  asynchronous, active-high reset.
- start  in  1  request an op; sampled only in IDLE.
- op  in  4  opcode.
- ra  in  AW  source A register address.
- rb  in  AW  source B register address.
- rd  in  AW  destination register address.
- busy  out  1  high in T_A, T_B and T_WB.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; high means reserved opcode.
- zero  out  1  registered flag: last written Z-low equals 0.
- ld_en  in  1  external register load strobe.
- ld_addr  in  AW  load address.
- ld_data  in  WIDTH  load data.
- rd_addr  in  AW  debug read address.
- rd_data  out  WIDTH  combinational R[rd_addr].
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (clear high, asynchronous):
  - All R[i], Y, Z (2*WIDTH bits), HI and LO go to 0.
  - FSM goes to IDLE.
  - busy, done, err and zero go to 0.
  - Asserting clear mid-operation aborts the op with no write-back and no done.
- Operand capture: at the edge that accepts start, op/ra/rb/rd are latched into internal registers. Later changes on these inputs do not affect the running op.
- FSM sequence: IDLE -> T_A -> T_B -> T_WB -> IDLE, one edge per step. start is ignored while busy.
  - T_A: bus = R[ra]; Y <= bus.
  - T_B: bus = R[rb]; Z <= ALU(Y, bus).
  - T_WB:
    - MUL/DIV: HI <= Z[2W-1:W]; LO <= Z[W-1:0]; rd is not written.
    - Other legal ops: bus = Z[W-1:0]; R[rd] <= bus.
    - zero <= (Z[W-1:0] == 0).
    - done <= 1 for the following cycle.
- Latency: start accepted at edge k -> write-back at edge k+3 -> done high from edge k+3 to edge k+4.
  - A new start may be accepted at edge k+4, which is the cycle done is high.
- ALU ops (signed where noted; Z-high = 0 for non-MUL/DIV):
  - 0 ADD, Y+B
  - 1 SUB, Y-B
  - 2 AND
  - 3 OR
  - 4 SHR, logical
  - 5 SHRA, arithmetic
  - 6 SHL
  - 7 ROR
  - 8 ROL
  - 9 MUL, signed, full 2W product
  - 10 DIV, signed: LO = quotient, HI = remainder, sign follows dividend
  - 11 NEG, -Y; B ignored
  - 12 NOT, ~Y; B ignored
  - 13-15 reserved: no register/HI/LO write, zero unchanged, done pulses with err=1.
- Shift and rotate amount = B[clog2(WIDTH)-1:0].
- Add/sub wrap modulo 2^WIDTH.
- DIV by zero: LO = all ones, HI = Y.
- Load port:
  - ld_en writes R[ld_addr] <= ld_data at the edge, only when the FSM is in IDLE. It is ignored in every other state.
  - ld_en and start at the same IDLE edge: the load completes, and T_A then reads the loaded value.
- The write-back and read ports are independent. rd_data shows the new value from the cycle after the write edge.

Optional Feature:
- Macro R0_ZERO_EN.
- Defined:
  - R0 always reads 0 on the bus and on rd_data.
  - Writes to R0 from write-back or ld_en are discarded.
  - zero is still computed from Z.
- Undefined: R0 is an ordinary register.

Test Plan:
- Reset mid-op: load R1=5, R2=7; start ADD ra=1 rb=2 rd=3; assert clear during T_B -> R1..R3=0, busy=0, no done pulse.
- ADD latency: R1=5, R2=7, ADD rd=3 started at edge k -> busy high for edges k..k+3, done exactly at k+3..k+4, R3=12, zero=0; a start held during busy is ignored.
- MUL/DIV: R4=-3 (0xFFFFFFFD), R5=4 -> MUL gives HI=0xFFFFFFFF, LO=0xFFFFFFF4, R[rd] unchanged; DIV R4/R5 gives LO=0 (quotient 0), HI=0xFFFFFFFD, zero=1; DIV by R6=0 gives LO=0xFFFFFFFF, HI=0xFFFFFFFD.
- Shifts and rotates: R1=0x80000001, R2=33 (amount 1) -> SHR=0x40000000, SHRA=0xC0000000, SHL=0x00000002, ROR=0xC0000000, ROL=0x00000003.
- Handshake edges: ld_en R7=9 together with start SUB ra=7 rb=7 rd=8 -> R8=0, zero=1; ld_en during busy ignored; op=14 gives done with err=1 and no register change.
- R0_ZERO_EN: ld R0=0xAA, ADD ra=0 rb=0 rd=1 -> defined: rd_data(R0)=0, R1=0; undefined: R0=0xAA, R1=0x154.
